// File: rtl/frame_gate.sv
// rtl/frame_gate.sv - drops settling samples after a ramp start, then emits exactly N samples per frame
module frame_gate #(
  parameter int N               = 1024,
  parameter int DATA_WIDTH      = 14,
  parameter int SKIP_WIDTH      = 10,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [SKIP_WIDTH-1:0]        skip,
  input  logic                         adc_valid,
  input  logic signed [DATA_WIDTH-1:0] adc_data,
  output logic                         dvalid,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         frame_first,
  output logic                         frame_last,
  output logic                         busy,
  output logic                         missed,
  output logic [FRAME_CNT_WIDTH-1:0]   frame_cnt
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SKIP, EMIT} state_t;

  state_t                       r_state, w_next_state;
  logic [SKIP_WIDTH-1:0]        r_skip_rem, w_next_skip_rem;
  logic [CW-1:0]                r_emit_cnt, w_next_emit_cnt;

  // Effective frame context for this cycle: a fresh start (from IDLE or SKIP)
  // replaces the registered context so the start-cycle sample gets index 0.
  state_t                       w_cur_state;
  logic [SKIP_WIDTH-1:0]        w_cur_skip_rem;
  logic [CW-1:0]                w_cur_emit_cnt;
  logic                         w_load;
  logic                         w_emit, w_first, w_last, w_missed;

  logic                         r_dvalid, r_first, r_last, r_missed;
  logic signed [DATA_WIDTH-1:0] r_dout;
  logic [FRAME_CNT_WIDTH-1:0]   r_frame_cnt;

  // Next-state and per-sample decisions; counters only move on adc_valid.
  always_comb begin
    w_load         = start && (r_state != EMIT);
    w_cur_state    = r_state;
    w_cur_skip_rem = r_skip_rem;
    w_cur_emit_cnt = r_emit_cnt;
    if (w_load) begin
      w_cur_state    = (skip == '0) ? EMIT : SKIP;
      w_cur_skip_rem = skip;
      w_cur_emit_cnt = '0;
    end

    w_next_state    = w_cur_state;
    w_next_skip_rem = w_cur_skip_rem;
    w_next_emit_cnt = w_cur_emit_cnt;
    w_emit          = 1'b0;
    w_first         = 1'b0;
    w_last          = 1'b0;
    w_missed        = 1'b0;

    case (w_cur_state)
      SKIP: begin
        if (adc_valid) begin
          w_next_skip_rem = w_cur_skip_rem - SKIP_WIDTH'(1);
          if (w_cur_skip_rem == SKIP_WIDTH'(1)) begin
            w_next_state    = EMIT;
            w_next_emit_cnt = '0;
          end
        end
      end
      EMIT: begin
        if (adc_valid) begin
          w_emit  = 1'b1;
          w_first = (w_cur_emit_cnt == '0);
          w_last  = (w_cur_emit_cnt == LAST_IDX);
          if (w_last) begin
            w_next_emit_cnt = '0;
            // A start coinciding with the final sample opens the next frame;
            // the coincident sample itself stays with the old frame.
            if (start && r_state == EMIT) begin
              w_next_state    = (skip == '0) ? EMIT : SKIP;
              w_next_skip_rem = skip;
            end else begin
              w_next_state = IDLE;
            end
          end else begin
            w_next_emit_cnt = w_cur_emit_cnt + CW'(1);
          end
        end
      end
      default: ;
    endcase

    if (start && r_state == EMIT && !w_last) begin
      w_missed = 1'b1;
    end
  end

  // Frame state and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_skip_rem <= '0;
      r_emit_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_skip_rem <= w_next_skip_rem;
      r_emit_cnt <= w_next_emit_cnt;
    end
  end

  // One-cycle registered output stage; dout holds between valid samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dvalid    <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_missed    <= 1'b0;
      r_dout      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_dvalid <= w_emit;
      r_first  <= w_first;
      r_last   <= w_last;
      r_missed <= w_missed;
      if (w_emit) begin
        r_dout <= adc_data;
      end
      if (w_last) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_WIDTH'(1);
      end
    end
  end

  assign dvalid      = r_dvalid;
  assign dout        = r_dout;
  assign frame_first = r_first;
  assign frame_last  = r_last;
  assign missed      = r_missed;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = (r_state != IDLE);

endmodule
